// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores over a valid/ready command port, aligns
// returned load data to bit 0 and registers every field consumed by write-back.
// Optional build macro: MEM_STAGE_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses are not issued and are flagged on out_misaligned instead.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [31:0] in_reg_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2_data,
  input  logic        in_mem_wen,
  input  logic [1:0]  in_store_size,
  input  logic [3:0]  in_wb_sel,
  input  logic [31:0] in_csr_rdata,
  input  logic [31:0] in_br_target,
  input  logic [31:0] in_trap_vector,
  input  logic [4:0]  in_wb_addr,
  input  logic [2:0]  in_csr_cmd,
  input  logic        in_jmp_flg,
  input  logic        in_rf_wen,
  input  logic        in_br_flg,
  output logic        stall,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] out_reg_pc,
  output logic [3:0]  out_wb_sel,
  output logic [31:0] out_memory_rdata,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_csr_rdata,
  output logic [31:0] out_br_target,
  output logic [31:0] out_trap_vector,
  output logic [4:0]  out_wb_addr,
  output logic [2:0]  out_csr_cmd,
  output logic        out_jmp_flg,
  output logic        out_rf_wen,
  output logic        out_br_flg,
  output logic        out_misaligned
);

  // Write-back select encodings for loads (mirrors include/core.v)
  localparam logic [3:0] WbMemW  = 4'd1;
  localparam logic [3:0] WbMemB  = 4'd2;
  localparam logic [3:0] WbMemBu = 4'd3;
  localparam logic [3:0] WbMemH  = 4'd4;
  localparam logic [3:0] WbMemHu = 4'd5;

  localparam logic [31:0] BubblePc = 32'hffffffff;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        write_q;
  logic [31:0] rdata_q;

  logic        is_load;
  logic        is_mem;
  logic [1:0]  acc_size;
  logic [1:0]  off;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        trap;
  logic        issue;
  logic        do_bubble;
  logic        do_capture;

  // Decode the incoming instruction: memory op, access size and store lanes
  always_comb begin
    is_load  = (in_wb_sel == WbMemW) || (in_wb_sel == WbMemB) || (in_wb_sel == WbMemBu) ||
               (in_wb_sel == WbMemH) || (in_wb_sel == WbMemHu);
    is_mem   = in_mem_wen || is_load;
    off      = in_alu_out[1:0];
    acc_size = 2'd2;
    if (in_mem_wen) begin
      acc_size = in_store_size;
    end else if ((in_wb_sel == WbMemB) || (in_wb_sel == WbMemBu)) begin
      acc_size = 2'd0;
    end else if ((in_wb_sel == WbMemH) || (in_wb_sel == WbMemHu)) begin
      acc_size = 2'd1;
    end
    // Lanes that would land past byte 3 fall off the 4-bit mask / 32-bit data
    case (acc_size)
      2'd0: begin
        st_wdata = {4{in_rs2_data[7:0]}};
        st_wmask = 4'b0001 << off;
      end
      2'd1: begin
        st_wdata = {2{in_rs2_data[15:0]}};
        st_wmask = 4'b0011 << off;
      end
      default: begin
        st_wdata = in_rs2_data << {off, 3'b000};
        st_wmask = 4'b1111 << off;
      end
    endcase
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic misaligned_q;

  // Misaligned half/word accesses are retired in IDLE without a command
  assign trap = is_mem && (((acc_size == 2'd1) && off[0]) ||
                           ((acc_size >= 2'd2) && (off != 2'b00)));
  assign out_misaligned = misaligned_q;

  // Flag follows each captured instruction; bubbles and memory results clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (do_bubble) begin
      misaligned_q <= 1'b0;
    end else if (do_capture) begin
      misaligned_q <= (state_q == StIdle) && trap;
    end
  end
`else
  assign trap           = 1'b0;
  assign out_misaligned = 1'b0;
`endif

  // Stage control: when to start a command, emit a bubble or capture into out_*
  always_comb begin
    issue      = (state_q == StIdle) && in_valid && !flush && is_mem && !trap;
    do_bubble  = (state_q == StIdle) && (!in_valid || flush || issue);
    do_capture = ((state_q == StIdle) && !do_bubble) || (state_q == StDone);
    // Gated by reset so upstream is released the moment reset asserts
    stall      = rst_n && (issue || (state_q == StReq) || (state_q == StWait));
  end

  assign mem_cmd_valid = (state_q == StReq);
  assign mem_cmd_write = write_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Transaction FSM; command fields latched on IDLE->REQ and held until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            addr_q  <= {in_alu_out[31:2], 2'b00};
            wdata_q <= in_mem_wen ? st_wdata : 32'd0;
            wmask_q <= in_mem_wen ? st_wmask : 4'd0;
            write_q <= in_mem_wen;
            rdata_q <= {30'd0, off};
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_cmd_ready) begin
            state_q <= write_q ? StDone : StWait;
          end
        end
        StWait: begin
          // rdata_q holds the byte offset until the load word returns
          if (mem_rdata_valid) begin
            rdata_q <= mem_rdata >> {rdata_q[1:0], 3'b000};
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Write-back register: bubble, or the instruction (plus load data when finishing)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg_pc       <= BubblePc;
      out_wb_sel       <= 4'd0;
      out_memory_rdata <= 32'd0;
      out_alu_out      <= 32'd0;
      out_csr_rdata    <= 32'd0;
      out_br_target    <= 32'd0;
      out_trap_vector  <= 32'd0;
      out_wb_addr      <= 5'd0;
      out_csr_cmd      <= 3'd0;
      out_jmp_flg      <= 1'b0;
      out_rf_wen       <= 1'b0;
      out_br_flg       <= 1'b0;
    end else if (do_bubble) begin
      out_reg_pc       <= BubblePc;
      out_wb_sel       <= 4'd0;
      out_memory_rdata <= 32'd0;
      out_alu_out      <= 32'd0;
      out_csr_rdata    <= 32'd0;
      out_br_target    <= 32'd0;
      out_trap_vector  <= 32'd0;
      out_wb_addr      <= 5'd0;
      out_csr_cmd      <= 3'd0;
      out_jmp_flg      <= 1'b0;
      out_rf_wen       <= 1'b0;
      out_br_flg       <= 1'b0;
    end else if (do_capture) begin
      // Upstream holds its inputs while stalled, so in_* is still the held instruction
      out_reg_pc       <= in_reg_pc;
      out_wb_sel       <= in_wb_sel;
      out_memory_rdata <= ((state_q == StDone) && !write_q) ? rdata_q : 32'd0;
      out_alu_out      <= in_alu_out;
      out_csr_rdata    <= in_csr_rdata;
      out_br_target    <= in_br_target;
      out_trap_vector  <= in_trap_vector;
      out_wb_addr      <= in_wb_addr;
      out_csr_cmd      <= in_csr_cmd;
      out_jmp_flg      <= in_jmp_flg;
      out_rf_wen       <= in_rf_wen && !((state_q == StIdle) && trap);
      out_br_flg       <= in_br_flg;
    end
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage: sits between the execute stage and the write-back stage. It takes one instruction per cycle, issues loads and stores to the data-memory port via a valid/ready command handshake, aligns load data so byte/half extraction always reads bits [7:0]/[15:0], and registers every field the write-back stage consumes. While a memory transaction is outstanding, it stalls upstream and feeds bubbles downstream.

## Interface
Parameters:
- none (bubble PC fixed at 32'hffffffff)

Ports (reset is asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present from execute
- flush  in  1  squash the incoming instruction (branch hazard from write-back)
- in_reg_pc  in  32  instruction PC
- in_alu_out  in  32  ALU result; the memory address for loads and stores
- in_rs2_data  in  32  store data
- in_mem_wen  in  1  1 = store
- in_store_size  in  2  0 = byte, 1 = half, 2 = word
- in_wb_sel  in  4  write-back select; WB_MEMB/MEMBU/MEMH/MEMHU/MEMW from include/core.v mark loads
- in_csr_rdata, in_br_target, in_trap_vector  in  32 each  sideband, passed through
- in_wb_addr  in  5; in_csr_cmd  in  3; in_jmp_flg, in_rf_wen, in_br_flg  in  1 each  sideband, passed through
- stall  out  1  upstream must hold its inputs constant
- mem_cmd_valid  out  1  command request
- mem_cmd_ready  in  1  command accepted
- mem_cmd_write  out  1  1 = store
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  4  byte-enable
- mem_rdata_valid  in  1  load data return
- mem_rdata  in  32  load word
- out_* (out_reg_pc, out_wb_sel, out_memory_rdata, out_alu_out, and every sideband field)  out  same width  registered to write-back
- out_misaligned  out  1  misaligned access flagged (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, DONE. Address, data, size, and type are latched on IDLE->REQ.
- A memory op is in_mem_wen=1, or in_wb_sel is one of the WB_MEM* codes.
- In IDLE with in_valid=1, flush=0, and a non-memory op: out_* captures the inputs at the edge; stall=0.
- In IDLE with in_valid=0 or flush=1: out_* becomes a bubble (out_reg_pc=32'hffffffff, out_rf_wen=0, out_jmp_flg=0, out_br_flg=0, out_csr_cmd=0); stall=0. Flush has priority over a memory op, so no command is issued.
- IDLE with a memory op -> REQ. Outputs become a bubble; stall=1.
- REQ: mem_cmd_valid=1. On mem_cmd_ready, a store goes to DONE and a load goes to WAIT. stall=1; outputs remain a bubble.
- WAIT: on mem_rdata_valid, capture mem_rdata >> (8*addr[1:0]) into the rdata holding register -> DONE. stall=1.
- DONE: stall=0. At the edge, out_* captures the held instruction plus rdata (0 for stores) -> IDLE.
- Store lanes:
  - byte: wdata = rs2[7:0] replicated to all lanes, wmask = 1<<addr[1:0]
  - half: wdata = {2{rs2[15:0]}}, wmask = 4'b0011<<addr[1:0], truncated to 4 bits
  - word: wmask = 4'b1111
- Loads: mem_cmd_write=0, mem_wmask=0.
- Flush is ignored outside IDLE; it cannot occur there because write-back only sees bubbles while this stage stalls.

## Timing
- Reset values: state IDLE; all out_* at bubble values; out_memory_rdata=0; out_misaligned=0; mem_cmd_valid=0; stall=0.
- Non-memory op: latency 1 (visible on out_* one edge after presentation).
- Store with immediate ready: presented in cycle 0; REQ in cycle 1; DONE in cycle 2; out_* valid after the cycle-2 edge.
- Load with ready immediate and rdata the following cycle: out_* valid after the cycle-3 edge.
- Each extra wait cycle on mem_cmd_ready or mem_rdata_valid adds one cycle.
- mem_cmd_valid, mem_addr, mem_wdata, mem_wmask, and mem_cmd_write are stable from REQ entry until the handshake completes.
- mem_rdata_valid is sampled only in WAIT.
- Reset mid-transaction: returns to IDLE immediately; the outstanding command is abandoned.

## Configuration
- MEM_STAGE_MISALIGN_CHECK_EN defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no command.
  - It completes in 1 cycle with out_misaligned=1 and out_rf_wen=0.
- MEM_STAGE_MISALIGN_CHECK_EN undefined:
  - out_misaligned is tied to 0.
  - Misaligned accesses issue normally; lanes beyond byte 3 are dropped from mask and data.

## Test plan
- ADD-type op, pc=0x100, alu_out=0x5 -> out_reg_pc=0x100, out_alu_out=0x5 one cycle later; stall never asserted.
- SB at addr 0x1003, rs2=0xAB, ready immediate -> mem_addr=0x1000, wmask=4'b1000, wdata=0xABABABAB; stall high for 2 cycles; out_memory_rdata=0.
- LBU at addr 0x2002, mem_rdata=0x11223344 returned after 3 wait cycles -> out_memory_rdata=0x00001122; stall high for exactly the wait cycles plus 2.
- in_valid=1 with flush=1 on an LW -> no mem_cmd_valid; out_reg_pc=0xffffffff, out_rf_wen=0.
- rst_n low while in WAIT -> stall=0, mem_cmd_valid=0, out_* at bubble values at once; a later rdata_valid is ignored.
- With MEM_STAGE_MISALIGN_CHECK_EN defined, LW at 0x3002 -> out_misaligned=1, out_rf_wen=0, no command. Undefined -> command issued with wmask=0.
